// File: rtl/wb_rect_fill_engine.sv
// Rectangle-fill blitter: a Wishbone slave register file programs a clipped rectangle,
// and a Wishbone master writes one framebuffer pixel per request.
module wb_rect_fill_engine #(
    parameter int FB_W  = 160,
    parameter int FB_H  = 120,
    parameter int ADR_W = 17
) (
    input  logic             I_wb_clk,
    input  logic             I_wb_rst,
    input  logic [2:0]       I_s_adr,
    input  logic [7:0]       I_s_dat,
    input  logic             I_s_we,
    input  logic             I_s_stb,
    input  logic             I_s_cyc,
    output logic             O_s_ack,
    output logic [7:0]       O_s_dat,
    output logic [ADR_W-1:0] O_m_adr,
    output logic [7:0]       O_m_dat,
    output logic             O_m_we,
    output logic             O_m_stb,
    output logic             O_m_cyc,
    input  logic             I_m_ack,
    output logic             O_busy,
    output logic             O_done
);
    localparam int PIX_W = ADR_W - 2;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

    state_t             state_q, state_d;
    logic               s_ack_q, s_ack_d;
    logic [7:0]         s_dat_q, s_dat_d;
    logic [7:0]         x0_q, x0_d, w_q, w_d, color_q, color_d;
    logic [6:0]         y0_q, y0_d, h_q, h_d;
    logic [7:0]         lx0_q, lx0_d, lcolor_q, lcolor_d;
    logic [6:0]         ly0_q, ly0_d;
    logic [8:0]         xe_q, xe_d, ye_q, ye_d;
    logic               empty_q, empty_d;
    logic               start_q, start_d;
    logic [7:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [7:0]         dat_q, dat_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sticky_q, sticky_d;

    logic       s_acc, s_wr, s_rd, ctrl_wr, abort_req, start_req;
    logic [8:0] x_sum, y_sum, x_inc, y_inc;

    // Pixel index y*160 + x built from shifts so no multiplier is needed.
    function automatic logic [ADR_W-1:0] pix_adr(input logic [6:0] y, input logic [7:0] x);
        logic [PIX_W-1:0] p;
        p = PIX_W'({y, 7'b0}) + PIX_W'({y, 5'b0}) + PIX_W'(x);
        return {p, 2'b00};
    endfunction

    assign s_acc     = I_s_stb & I_s_cyc & ~s_ack_q;
    assign s_wr      = s_acc & I_s_we;
    assign s_rd      = s_acc & ~I_s_we;
    assign ctrl_wr   = s_wr & (I_s_adr == 3'd5);
    assign abort_req = ctrl_wr & I_s_dat[1] & (busy_q | start_q);
    assign start_req = ctrl_wr & I_s_dat[0] & ~I_s_dat[1] & ~busy_q & ~start_q;

    assign x_sum = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum = {2'b0, y0_q} + {2'b0, h_q};
    assign x_inc = {1'b0, x_q} + 9'd1;
    assign y_inc = {2'b0, y_q} + 9'd1;

    always_comb begin
        state_d  = state_q;
        s_ack_d  = s_acc;
        s_dat_d  = s_dat_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        lx0_d    = lx0_q;
        ly0_d    = ly0_q;
        lcolor_d = lcolor_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        empty_d  = empty_q;
        start_d  = start_q;
        x_d      = x_q;
        y_d      = y_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        stb_d    = stb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sticky_d = sticky_q;

        if (s_wr) begin
            case (I_s_adr)
                3'd0:    x0_d    = I_s_dat;
                3'd1:    y0_d    = I_s_dat[6:0];
                3'd2:    w_d     = I_s_dat;
                3'd3:    h_d     = I_s_dat[6:0];
                3'd4:    color_d = I_s_dat;
                default: ;
            endcase
        end

        if (s_rd) begin
            case (I_s_adr)
                3'd0:    s_dat_d = x0_q;
                3'd1:    s_dat_d = {1'b0, y0_q};
                3'd2:    s_dat_d = w_q;
                3'd3:    s_dat_d = {1'b0, h_q};
                3'd4:    s_dat_d = color_q;
                3'd5:    s_dat_d = {6'b0, sticky_q, busy_q};
                default: s_dat_d = 8'h00;
            endcase
            if (I_s_adr == 3'd5) sticky_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    start_d = 1'b0;
                    if (empty_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        stb_d   = 1'b1;
                        busy_d  = 1'b1;
                        x_d     = lx0_q;
                        y_d     = ly0_q;
                        adr_d   = pix_adr(ly0_q, lx0_q);
                        dat_d   = lcolor_q;
                    end
                end
            end
            ST_REQ: begin
                if (I_m_ack) begin
                    state_d = ST_GAP;
                    stb_d   = 1'b0;
                end
            end
            ST_GAP: begin
                // A registered-ack slave still shows its ack here; it is deliberately ignored.
                if (x_inc == xe_q) begin
                    if (y_inc == ye_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        stb_d   = 1'b1;
                        x_d     = lx0_q;
                        y_d     = y_inc[6:0];
                        adr_d   = pix_adr(y_inc[6:0], lx0_q);
                    end
                end else begin
                    state_d = ST_REQ;
                    stb_d   = 1'b1;
                    x_d     = x_inc[7:0];
                    adr_d   = pix_adr(y_q, x_inc[7:0]);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Operands are snapshotted here so register writes during a fill cannot disturb it.
        if (start_req) begin
            start_d  = 1'b1;
            lx0_d    = x0_q;
            ly0_d    = y0_q;
            lcolor_d = color_q;
            xe_d     = (x_sum > 9'(FB_W)) ? 9'(FB_W) : x_sum;
            ye_d     = (y_sum > 9'(FB_H)) ? 9'(FB_H) : y_sum;
            empty_d  = ({1'b0, x0_q} >= 9'(FB_W)) | ({2'b0, y0_q} >= 9'(FB_H)) |
                       (w_q == 8'd0) | (h_q == 7'd0);
        end

        if (abort_req) begin
            state_d = ST_IDLE;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
            start_d = 1'b0;
            done_d  = 1'b1;
        end

        if (done_d) sticky_d = 1'b1;
    end

    always_ff @(posedge I_wb_clk or posedge I_wb_rst) begin
        if (I_wb_rst) begin
            state_q  <= ST_IDLE;
            s_ack_q  <= 1'b0;
            s_dat_q  <= 8'h00;
            x0_q     <= 8'h00;
            y0_q     <= 7'h00;
            w_q      <= 8'h00;
            h_q      <= 7'h00;
            color_q  <= 8'h00;
            lx0_q    <= 8'h00;
            ly0_q    <= 7'h00;
            lcolor_q <= 8'h00;
            xe_q     <= 9'h000;
            ye_q     <= 9'h000;
            empty_q  <= 1'b0;
            start_q  <= 1'b0;
            x_q      <= 8'h00;
            y_q      <= 7'h00;
            adr_q    <= '0;
            dat_q    <= 8'h00;
            stb_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_ack_q  <= s_ack_d;
            s_dat_q  <= s_dat_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            color_q  <= color_d;
            lx0_q    <= lx0_d;
            ly0_q    <= ly0_d;
            lcolor_q <= lcolor_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            empty_q  <= empty_d;
            start_q  <= start_d;
            x_q      <= x_d;
            y_q      <= y_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            stb_q    <= stb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sticky_q <= sticky_d;
        end
    end

    assign O_s_ack = s_ack_q;
    assign O_s_dat = s_dat_q;
    assign O_m_adr = adr_q;
    assign O_m_dat = dat_q;
    assign O_m_stb = stb_q;
    assign O_m_cyc = stb_q;
    assign O_m_we  = stb_q;
    assign O_busy  = busy_q;
    assign O_done  = done_q;

endmodule

// File: tb/tb_wb_rect_fill_engine.sv
// Directed bench for wb_rect_fill_engine with a registered-ack framebuffer model
// that optionally inserts wait cycles.
module tb_wb_rect_fill_engine;
    localparam int ADR_W = 17;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       s_adr;
    logic [7:0]       s_dat;
    logic             s_we, s_stb, s_cyc;
    logic             O_s_ack;
    logic [7:0]       O_s_dat;
    logic [ADR_W-1:0] O_m_adr;
    logic [7:0]       O_m_dat;
    logic             O_m_we, O_m_stb, O_m_cyc;
    logic             m_ack;
    logic             O_busy, O_done;

    always #5 clk = ~clk;

    wb_rect_fill_engine #(.FB_W(160), .FB_H(120), .ADR_W(ADR_W)) dut (
        .I_wb_clk(clk),
        .I_wb_rst(rst),
        .I_s_adr(s_adr),
        .I_s_dat(s_dat),
        .I_s_we(s_we),
        .I_s_stb(s_stb),
        .I_s_cyc(s_cyc),
        .O_s_ack(O_s_ack),
        .O_s_dat(O_s_dat),
        .O_m_adr(O_m_adr),
        .O_m_dat(O_m_dat),
        .O_m_we(O_m_we),
        .O_m_stb(O_m_stb),
        .O_m_cyc(O_m_cyc),
        .I_m_ack(m_ack),
        .O_busy(O_busy),
        .O_done(O_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Framebuffer slave: ack registered, held while stb stays high (produces the stale ack).
    int fb_wait = 0;
    int fb_cnt  = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack  <= 1'b0;
            fb_cnt <= 0;
        end else if (O_m_stb && O_m_cyc) begin
            if (fb_cnt >= fb_wait) m_ack <= 1'b1;
            else                   fb_cnt <= fb_cnt + 1;
        end else begin
            m_ack  <= 1'b0;
            fb_cnt <= 0;
        end
    end

    // Monitor on the falling edge, away from the active edge.
    int cyc_n = 0, done_cnt = 0, done_cyc = 0, busy_cyc = 0, stb_cyc = 0;
    int stab_err = 0, wr_cnt = 0, ack_cyc = 0;
    logic [ADR_W+7:0] wr_q[$];
    logic             prev_stb = 1'b0;
    logic [ADR_W-1:0] prev_adr = '0;
    logic [7:0]       prev_dat = 8'h00;

    always @(negedge clk) begin
        cyc_n++;
        if (O_done) begin done_cnt++; done_cyc = cyc_n; end
        if (O_busy) busy_cyc++;
        if (O_m_stb) stb_cyc++;
        if (O_m_stb && prev_stb && (O_m_adr !== prev_adr || O_m_dat !== prev_dat)) stab_err++;
        if (O_m_stb && m_ack && O_m_we) begin
            wr_q.push_back({O_m_adr, O_m_dat});
            wr_cnt++;
        end
        prev_stb = O_m_stb;
        prev_adr = O_m_adr;
        prev_dat = O_m_dat;
    end

    task automatic wb_xfer(input logic [2:0] a, input logic [7:0] d, input logic we,
                           output logic [7:0] rd);
        int n;
        @(negedge clk);
        s_adr = a; s_dat = d; s_we = we; s_stb = 1'b1; s_cyc = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!O_s_ack && n < 20);
        if (!O_s_ack) check("s_ack_timeout", 32'(O_s_ack), 32'd1);
        ack_cyc = cyc_n;
        rd = O_s_dat;
        s_stb = 1'b0; s_cyc = 1'b0; s_we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] t;
        wb_xfer(a, d, 1'b1, t);
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        wb_xfer(a, 8'h00, 1'b0, d);
    endtask

    task automatic program_rect(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                                input logic [7:0] h, input logic [7:0] c);
        wr(3'd0, x); wr(3'd1, y); wr(3'd2, w); wr(3'd3, h); wr(3'd4, c);
    endtask

    task automatic wait_done(input int base);
        int n = 0;
        while (done_cnt == base && n < 5000) begin
            @(posedge clk); n++;
        end
        repeat (4) @(posedge clk);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [ADR_W-1:0] a,
                          input logic [7:0] d);
        if (idx < wr_q.size()) check(tag, 32'(wr_q[idx]), 32'({a, d}));
        else                   check(tag, 32'hFFFF_FFFF, 32'({a, d}));
    endtask

    initial begin
        logic [7:0] r;
        int b_done, b_busy, b_stb, b_stab, b_wr, n;

        rst = 1'b1;
        s_adr = '0; s_dat = '0; s_we = 1'b0; s_stb = 1'b0; s_cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_adr", 32'(O_m_adr), 32'd0);
        check("rst_misc", 32'({O_s_ack, O_s_dat, O_m_dat, O_m_we, O_m_stb, O_m_cyc, O_busy, O_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Register file readback
        rd(3'd4, r);          check("rd_color_rst", 32'(r), 32'h00);
        wr(3'd0, 8'h5A);      rd(3'd0, r); check("rd_x0", 32'(r), 32'h5A);
        wr(3'd1, 8'hFF);      rd(3'd1, r); check("rd_y0_7bit", 32'(r), 32'h7F);
        wr(3'd6, 8'h33);      rd(3'd6, r); check("rd_reserved", 32'(r), 32'h00);

        // 2x2 fill at origin
        fb_wait = 0;
        program_rect(8'd0, 8'd0, 8'd2, 8'd2, 8'hE0);
        wr_q.delete();
        b_done = done_cnt; b_busy = busy_cyc;
        wr(3'd5, 8'h01);
        n = ack_cyc;
        wait_done(b_done);
        check("f1_count", 32'(wr_q.size()), 32'd4);
        chk_wr("f1_w0", 0, 17'h00000, 8'hE0);
        chk_wr("f1_w1", 1, 17'h00004, 8'hE0);
        chk_wr("f1_w2", 2, 17'h00280, 8'hE0);
        chk_wr("f1_w3", 3, 17'h00284, 8'hE0);
        check("f1_done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("f1_busy_cycles", 32'(busy_cyc - b_busy), 32'd12);
        check("f1_done_latency", 32'(done_cyc - n), 32'd14);
        rd(3'd5, r); check("f1_ctrl", 32'(r), 32'h02);

        // Clipped at bottom-right corner
        program_rect(8'd158, 8'd119, 8'd10, 8'd10, 8'h1C);
        wr_q.delete();
        b_done = done_cnt;
        wr(3'd5, 8'h01);
        wait_done(b_done);
        check("clip_count", 32'(wr_q.size()), 32'd2);
        chk_wr("clip_w0", 0, 17'h12BF8, 8'h1C);
        chk_wr("clip_w1", 1, 17'h12BFC, 8'h1C);
        rd(3'd5, r); check("clip_ctrl", 32'(r), 32'h02);

        // Empty rectangle (W=0)
        program_rect(8'd0, 8'd0, 8'd0, 8'd5, 8'hFF);
        b_done = done_cnt; b_stb = stb_cyc;
        wr(3'd5, 8'h01);
        n = ack_cyc;
        repeat (6) @(posedge clk);
        check("w0_done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("w0_done_latency", 32'(done_cyc - n), 32'd2);
        check("w0_no_stb", 32'(stb_cyc - b_stb), 32'd0);
        rd(3'd5, r); check("w0_ctrl1", 32'(r), 32'h02);
        rd(3'd5, r); check("w0_ctrl2", 32'(r), 32'h00);

        // Empty rectangle (X0 off screen)
        program_rect(8'd200, 8'd0, 8'd5, 8'd5, 8'hFF);
        b_done = done_cnt; b_stb = stb_cyc;
        wr(3'd5, 8'h01);
        repeat (6) @(posedge clk);
        check("xoff_done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("xoff_no_stb", 32'(stb_cyc - b_stb), 32'd0);
        rd(3'd5, r);

        // Wait-state slave
        fb_wait = 3;
        program_rect(8'd5, 8'd3, 8'd3, 8'd1, 8'h5A);
        wr_q.delete();
        b_done = done_cnt; b_busy = busy_cyc; b_stab = stab_err;
        wr(3'd5, 8'h01);
        wait_done(b_done);
        check("ws_count", 32'(wr_q.size()), 32'd3);
        chk_wr("ws_w0", 0, 17'h00794, 8'h5A);
        chk_wr("ws_w1", 1, 17'h00798, 8'h5A);
        chk_wr("ws_w2", 2, 17'h0079C, 8'h5A);
        check("ws_stable", 32'(stab_err - b_stab), 32'd0);
        check("ws_busy_cycles", 32'(busy_cyc - b_busy), 32'd18);
        fb_wait = 0;
        rd(3'd5, r);

        // Full-screen fill aborted after 100 pixels
        program_rect(8'd0, 8'd0, 8'd160, 8'd120, 8'h03);
        b_wr = wr_cnt; b_done = done_cnt;
        wr(3'd5, 8'h01);
        n = 0;
        while ((wr_cnt - b_wr) < 100 && n < 2000) begin
            @(posedge clk); n++;
        end
        wr(3'd5, 8'h02);
        check("abort_stb", 32'(O_m_stb), 32'd0);
        check("abort_busy", 32'(O_busy), 32'd0);
        check("abort_done", 32'(O_done), 32'd1);
        repeat (6) @(posedge clk);
        check("abort_ge100", 32'((wr_cnt - b_wr) >= 100), 32'd1);
        check("abort_le101", 32'((wr_cnt - b_wr) <= 101), 32'd1);
        check("abort_done_pulses", 32'(done_cnt - b_done), 32'd1);
        rd(3'd5, r); check("abort_ctrl", 32'(r), 32'h02);

        // START together with ABORT while idle starts nothing
        b_stb = stb_cyc; b_done = done_cnt;
        wr(3'd5, 8'h03);
        repeat (6) @(posedge clk);
        check("sa_no_stb", 32'(stb_cyc - b_stb), 32'd0);
        check("sa_no_done", 32'(done_cnt - b_done), 32'd0);

        // Asynchronous reset in the middle of a fill
        program_rect(8'd0, 8'd0, 8'd160, 8'd120, 8'h55);
        wr(3'd5, 8'h01);
        repeat (30) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_adr", 32'(O_m_adr), 32'd0);
        check("arst_misc", 32'({O_s_ack, O_s_dat, O_m_dat, O_m_we, O_m_stb, O_m_cyc, O_busy, O_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        program_rect(8'd10, 8'd20, 8'd1, 8'd2, 8'h99);
        wr_q.delete();
        b_done = done_cnt;
        wr(3'd5, 8'h01);
        wait_done(b_done);
        check("post_rst_count", 32'(wr_q.size()), 32'd2);
        chk_wr("post_rst_w0", 0, 17'h03228, 8'h99);
        chk_wr("post_rst_w1", 1, 17'h034A8, 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
